// File: rtl/ifu_fetch_pkg.sv
// Shared types, constants and helpers for the instruction fetch unit.
`ifndef InstWidth
`define InstWidth 32
`endif
`ifndef NOP_INST
`define NOP_INST 32'h0000_0013
`endif

package ifu_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_FULL = 2'd3
  } ifu_state_t;

  localparam logic [`InstWidth-1:0] NOP_INST = `NOP_INST;

  // A faulting fetch hands the decoder a harmless nop; the err flag carries the trap.
  function automatic logic [`InstWidth-1:0] inst_or_nop(input logic [`InstWidth-1:0] data,
                                                       input logic err);
    return err ? NOP_INST : data;
  endfunction

endpackage

// File: rtl/ifu_inst_buf.sv
// One-entry {inst, pc, err} holding register between memory response and decoder.
`ifndef InstWidth
`define InstWidth 32
`endif

module ifu_inst_buf
  import ifu_fetch_pkg::*;
#(
  parameter int PC_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_set,
  input  logic                  i_clr,
  input  logic [`InstWidth-1:0] i_inst,
  input  logic [PC_W-1:0]       i_pc,
  input  logic                  i_err,
  output logic                  o_valid,
  output logic [`InstWidth-1:0] o_inst,
  output logic [PC_W-1:0]       o_pc,
  output logic                  o_err
);

  logic                  r_valid;
  logic [`InstWidth-1:0] r_inst;
  logic [PC_W-1:0]       r_pc;
  logic                  r_err;

  // Clear wins so a flush can never be overtaken by a late write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_inst  <= '0;
      r_pc    <= '0;
      r_err   <= 1'b0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end else if (i_set) begin
      r_valid <= 1'b1;
      r_inst  <= inst_or_nop(i_inst, i_err);
      r_pc    <= i_pc;
      r_err   <= i_err;
    end
  end

  assign o_valid = r_valid;
  assign o_inst  = r_inst;
  assign o_pc    = r_pc;
  assign o_err   = r_err;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: PC, single-outstanding fetch FSM, redirect flush.
// Optional IFU_PERF_EN adds fetch and decoder-stall counters.
`ifndef InstWidth
`define InstWidth 32
`endif

module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(64'h8000_0000)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [PC_W-1:0]       redirect_pc,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [PC_W-1:0]       mem_req_addr,
  input  logic                  mem_resp_valid,
  input  logic [`InstWidth-1:0] mem_resp_data,
  input  logic                  mem_resp_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [`InstWidth-1:0] out_inst,
  output logic [PC_W-1:0]       out_pc,
  output logic                  out_err
`ifdef IFU_PERF_EN
  ,
  output logic [63:0]           perf_fetch_cnt,
  output logic [63:0]           perf_stall_cnt
`endif
);

  localparam logic [PC_W-1:0] PC_STEP    = PC_W'(4);
  localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

  ifu_state_t      r_state, w_state_next;
  logic [PC_W-1:0] r_pc, w_pc_next;
  logic [PC_W-1:0] r_req_addr;
  logic            r_drop, w_drop_next;
  logic            w_buf_set, w_buf_clr, w_out_valid;

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_drop_next  = r_drop;
    w_buf_set    = 1'b0;
    w_buf_clr    = 1'b0;
    case (r_state)
      ST_IDLE: w_state_next = ST_REQ;
      ST_REQ:  if (mem_req_ready) w_state_next = ST_WAIT;
      ST_WAIT: begin
        if (mem_resp_valid) begin
          if (r_drop) begin
            w_drop_next  = 1'b0;
            w_state_next = ST_REQ;
          end else begin
            w_buf_set    = 1'b1;
            w_pc_next    = r_pc + PC_STEP;
            w_state_next = ST_FULL;
          end
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          w_buf_clr    = 1'b1;
          w_state_next = ST_REQ;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase

    // Redirect overrides everything; any fetch already issued (or stuck in REQ) is marked stale.
    if (redirect_valid) begin
      w_pc_next = redirect_pc & ALIGN_MASK;
      w_buf_set = 1'b0;
      w_buf_clr = 1'b1;
      case (r_state)
        ST_REQ:  w_drop_next = 1'b1;
        ST_WAIT: begin
          if (mem_resp_valid) begin
            w_drop_next  = 1'b0;
            w_state_next = ST_REQ;
          end else begin
            w_drop_next  = 1'b1;
            w_state_next = ST_WAIT;
          end
        end
        default: w_state_next = ST_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC;
      r_drop     <= 1'b0;
      r_req_addr <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_drop  <= w_drop_next;
      // Address is captured only on entry to REQ so a pending request never changes under memory.
      if (w_state_next == ST_REQ && r_state != ST_REQ) r_req_addr <= w_pc_next;
    end
  end

  ifu_inst_buf #(
    .PC_W(PC_W)
  ) u_inst_buf (
    .clk     (clk),
    .rst     (rst),
    .i_set   (w_buf_set),
    .i_clr   (w_buf_clr),
    .i_inst  (mem_resp_data),
    .i_pc    (r_pc),
    .i_err   (mem_resp_err),
    .o_valid (w_out_valid),
    .o_inst  (out_inst),
    .o_pc    (out_pc),
    .o_err   (out_err)
  );

  assign mem_req_valid = (r_state == ST_REQ);
  assign mem_req_addr  = r_req_addr;
  assign out_valid     = w_out_valid;

`ifdef IFU_PERF_EN
  logic [63:0] r_fetch_cnt, r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_buf_set) r_fetch_cnt <= r_fetch_cnt + 64'd1;
      if (w_out_valid && !out_ready) r_stall_cnt <= r_stall_cnt + 64'd1;
    end
  end

  assign perf_fetch_cnt = r_fetch_cnt;
  assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized scoreboard bench for ifu_fetch: memory model, redirects, stalls, mid-fetch reset.
module tb_ifu_fetch;

  localparam logic [63:0] RESET_PC = 64'h8000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam int          NCYC     = 4000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [63:0] mem_req_addr;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = '0;
  logic        mem_resp_err = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [63:0] out_pc;
  logic        out_err;
`ifdef IFU_PERF_EN
  logic [63:0] perf_fetch_cnt, perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  ifu_fetch #(
    .PC_W     (64),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .mem_resp_err   (mem_resp_err),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_err        (out_err)
`ifdef IFU_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every decoder handshake pops the next expected instruction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("spurious_out_valid", 64'(out_valid), 64'd0);
        end else begin
          e = sb_q.pop_front();
          $display("xfer pc=%h inst=%h err=%0b", out_pc, out_inst, out_err);
          chk("out_pc", out_pc, e.pc);
          chk("out_inst", 64'(out_inst), 64'(e.inst));
          chk("out_err", 64'(out_err), 64'(e.err));
        end
      end
    end
  end

  // Reference model state: architectural next-fetch PC and a stale-fetch marker.
  logic [63:0] m_pc = RESET_PC;
  bit          m_stale, pending, after_rst, want_out, want_req, held, stall_hold;
  bit          mid_rst_done, hs, timed_out;
  logic [63:0] held_addr, hold_pc;
  logic [31:0] hold_inst;
  int          lat, stall_left, last_hs;
  longint      fetch_cnt, stall_cnt;

  initial begin
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      if (rst) begin
        m_pc = RESET_PC; m_stale = 0; pending = 0; sb_q.delete();
        after_rst = 1; want_out = 0; want_req = 0; held = 0; stall_hold = 0;
        fetch_cnt = 0; stall_cnt = 0; last_hs = cyc;
      end else begin
        if (after_rst) begin
          chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
          chk("rst_req_addr", mem_req_addr, RESET_PC);
          chk("rst_out_valid", 64'(out_valid), 64'd0);
          chk("rst_out_inst", 64'(out_inst), 64'd0);
          chk("rst_out_pc", out_pc, 64'd0);
          chk("rst_out_err", 64'(out_err), 64'd0);
          after_rst = 0;
        end
        if (want_out) chk("resp_to_out_latency", 64'(out_valid), 64'd1);
        if (want_req) chk("out_to_req_latency", 64'(mem_req_valid), 64'd1);
        if (held) begin
          chk("req_not_retracted", 64'(mem_req_valid), 64'd1);
          chk("req_addr_stable", mem_req_addr, held_addr);
        end
        if (stall_hold) begin
          chk("stall_out_valid", 64'(out_valid), 64'd1);
          chk("stall_out_pc", out_pc, hold_pc);
          chk("stall_out_inst", 64'(out_inst), 64'(hold_inst));
        end
        if (mem_req_valid) chk("single_outstanding", 64'(pending || out_valid), 64'd0);
        want_out = 0; want_req = 0; held = 0;

        hs = out_valid && out_ready;
        if (hs) begin want_req = 1; last_hs = cyc; end
        if (out_valid && !out_ready) stall_cnt++;
        stall_hold = out_valid && !out_ready && !redirect_valid;
        hold_pc = out_pc; hold_inst = out_inst;

        if (mem_req_valid && mem_req_ready) begin
          if (!m_stale) chk("req_addr", mem_req_addr, m_pc);
          pending = 1;
          lat = $urandom_range(0, 3);
        end else if (mem_req_valid) begin
          held = 1;
          held_addr = mem_req_addr;
        end

        if (mem_resp_valid) begin
          pending = 0;
          if (m_stale || redirect_valid) begin
            m_stale = 0;
          end else begin
            sb_q.push_back('{inst: (mem_resp_err ? NOP : mem_resp_data), pc: m_pc, err: mem_resp_err});
            m_pc = m_pc + 64'd4;
            want_out = 1;
            fetch_cnt++;
          end
        end

        if (redirect_valid) begin
          m_pc = redirect_pc & ~64'h3;
          if (!hs) sb_q.delete();
          if (mem_req_valid || pending) m_stale = 1;
        end

        if (!timed_out && cyc - last_hs > 400) begin
          timed_out = 1;
          chk("progress_timeout", 64'(cyc - last_hs), 64'd0);
        end
      end

      @(posedge clk);
      #1;
      if (cyc < 1) rst = 1'b1;
      else if (cyc > NCYC / 2 && !mid_rst_done && pending) begin
        rst = 1'b1;
        mid_rst_done = 1;
      end else rst = 1'b0;

      mem_req_ready = ($urandom_range(0, 2) != 0);
      if (pending && !rst && lat == 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = $urandom;
        mem_resp_err   = ($urandom_range(0, 7) == 0);
      end else begin
        mem_resp_valid = 1'b0;
        if (pending && lat > 0) lat--;
      end

      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else if ($urandom_range(0, 19) == 0) begin
        out_ready = 1'b0;
        stall_left = 4;
      end else out_ready = ($urandom_range(0, 3) != 0);

      redirect_valid = !rst && ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0:       redirect_pc = {$urandom, $urandom};
        1:       redirect_pc = 64'h8000_0103;
        2:       redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
        default: redirect_pc = RESET_PC + 64'($urandom_range(0, 255));
      endcase
    end

`ifdef IFU_PERF_EN
    chk("perf_fetch_cnt", perf_fetch_cnt, 64'(fetch_cnt));
    chk("perf_stall_cnt", perf_stall_cnt, 64'(stall_cnt));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
